// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU operation and next-PC select encodings
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'd0:    alu_dec = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_dec = ALU_SLL;
      3'd2:    alu_dec = ALU_SLT;
      3'd3:    alu_dec = ALU_SLTU;
      3'd4:    alu_dec = ALU_XOR;
      3'd5:    alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational RV32I ALU with zero flag
module riscv_alu
  import riscv_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o
);
  always_comb begin
    case (op_i)
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLL:   result_o = a_i << b_i[4:0];
      ALU_SRL:   result_o = a_i >> b_i[4:0];
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SLT:   result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  result_o = {31'd0, a_i < b_i};
      ALU_PASSB: result_o = b_i;
      default:   result_o = a_i + b_i;
    endcase
  end
  assign zero_o = result_o == '0;
endmodule

// File: rtl/riscv_exec_mem_unit.sv
// riscv_exec_mem_unit: single-cycle RV32I decode, execute and word data memory
module riscv_exec_mem_unit
  import riscv_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] wb_data
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt, use_imm, use_pc, link, taken;
  logic        eq, lt, ltu;
  alu_op_e     op;
  pc_src_e     ps;
  logic [31:0] op_a, op_b, rdata;
  logic [AW-1:0] idx;
  logic [31:0] mem_q [DMEM_WORDS];
  logic        unused_bits;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign eq  = rs1_data == rs2_data;
  assign lt  = $signed(rs1_data) < $signed(rs2_data);
  assign ltu = rs1_data < rs2_data;
  // funct3[0] inverts the base compare; 010/011 are not branches
  assign taken = (funct3[2:1] == 2'b01) ? 1'b0
               : (funct3[2] ? (funct3[1] ? ltu : lt) : eq) ^ funct3[0];
  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ps        = PC_PLUS4;
    op        = ALU_ADD;
    use_imm   = 1'b0;
    use_pc    = 1'b0;
    link      = 1'b0;
    case (opcode)
      OP_R:      begin op = alu_dec(funct3, alt, 1'b1); reg_write = 1'b1; end
      OP_I:      begin op = alu_dec(funct3, alt, 1'b0); reg_write = 1'b1; use_imm = 1'b1; end
      OP_LOAD:   begin mem_read = 1'b1; reg_write = 1'b1; use_imm = 1'b1; end
      OP_STORE:  begin mem_write = 1'b1; use_imm = 1'b1; end
      OP_BRANCH: begin op = ALU_SUB; ps = taken ? PC_BRANCH : PC_PLUS4; end
      OP_LUI:    begin op = ALU_PASSB; reg_write = 1'b1; use_imm = 1'b1; end
      OP_AUIPC:  begin reg_write = 1'b1; use_imm = 1'b1; use_pc = 1'b1; end
      OP_JAL:    begin ps = PC_BRANCH; reg_write = 1'b1; link = 1'b1; end
      OP_JALR:   begin ps = PC_JALR; reg_write = 1'b1; link = 1'b1; end
      default:   ;
    endcase
  end
  assign op_a   = use_pc ? pc : rs1_data;
  assign op_b   = use_imm ? imm : rs2_data;
  assign alu_op = op;
  assign pc_src = ps;
  riscv_alu u_alu (
    .op_i     (op),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (alu_result),
    .zero_o   (zero)
  );
  assign idx     = alu_result[AW+1:2];
  assign rdata   = mem_read ? mem_q[idx] : '0;
  assign wb_data = mem_read ? rdata : link ? pc + 32'd4 : alu_result;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_write) begin
      mem_q[idx] <= rs2_data;
    end
  end
endmodule

// File: tb/tb_riscv_exec_mem_unit.sv
// tb_riscv_exec_mem_unit: scoreboard bench for the exec/mem stage
module tb_riscv_exec_mem_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0000007F, pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic        reg_write, mem_read, mem_write, zero;
  logic [3:0]  alu_op;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, wb_data;
  int total = 0;
  int bad = 0;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011, S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
  typedef struct packed {
    logic [2:0]  m;
    logic [31:0] alu;
    logic        z;
    logic [31:0] wb;
    logic        rw, mr, mw;
    logic [1:0]  pcs;
    logic [3:0]  op;
  } exp_t;
  exp_t  sbq[$];
  string tq[$];
  riscv_exec_mem_unit #(.DMEM_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .alu_result (alu_result),
    .zero       (zero),
    .wb_data    (wb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] ins(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction
  function automatic exp_t ex(input logic [2:0] m, input logic [31:0] alu, input logic z,
                              input logic [31:0] wb, input logic rw, mr, mw,
                              input logic [1:0] pcs, input logic [3:0] op);
    return '{m: m, alu: alu, z: z, wb: wb, rw: rw, mr: mr, mw: mw, pcs: pcs, op: op};
  endfunction
  task automatic drive(input string t, input logic r, input logic [31:0] in, p, a, b, im, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; instr = in; pc = p; rs1_data = a; rs2_data = b; imm = im;
    sbq.push_back(e);
    tq.push_back(t);
  endtask
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t  e;
      string t;
      e = sbq.pop_front();
      t = tq.pop_front();
      chk({t, ".rw"}, reg_write, e.rw);
      chk({t, ".mr"}, mem_read, e.mr);
      chk({t, ".mw"}, mem_write, e.mw);
      chk({t, ".pcs"}, pc_src, e.pcs);
      if (e.m[0]) chk({t, ".alu"}, alu_result, e.alu);
      if (e.m[0]) chk({t, ".zero"}, zero, e.z);
      if (e.m[1]) chk({t, ".wb"}, wb_data, e.wb);
      if (e.m[2]) chk({t, ".op"}, alu_op, e.op);
    end
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    drive("add",   0, ins(7'h00,0,R), 0, 7, 5, 0,              ex(7, 12, 0, 12, 1,0,0, 0, 0));
    drive("sub",   0, ins(7'h20,0,R), 0, 9, 9, 0,              ex(7, 0, 1, 0, 1,0,0, 0, 1));
    drive("srai",  0, ins(7'h20,5,I), 0, 32'h80000000, 0, 32'h404, ex(7, 32'hF8000000, 0, 32'hF8000000, 1,0,0, 0, 7));
    drive("sltu",  0, ins(7'h00,3,R), 0, 32'hFFFFFFFF, 1, 0,   ex(7, 0, 1, 0, 1,0,0, 0, 9));
    drive("slt",   0, ins(7'h00,2,R), 0, 32'hFFFFFFFF, 1, 0,   ex(7, 1, 0, 1, 1,0,0, 0, 8));
    drive("slli",  0, ins(7'h00,1,I), 0, 1, 0, 31,             ex(7, 32'h80000000, 0, 32'h80000000, 1,0,0, 0, 5));
    drive("addi7", 0, ins(7'h20,0,I), 0, 10, 0, 32'h405,       ex(7, 32'h40F, 0, 32'h40F, 1,0,0, 0, 0));
    drive("sw",    0, ins(7'h00,2,S), 0, 32'h100, 32'hDEADBEEF, 4, ex(7, 32'h104, 0, 32'h104, 0,0,1, 0, 0));
    drive("lw",    0, ins(7'h00,2,L), 0, 32'h100, 0, 4,        ex(7, 32'h104, 0, 32'hDEADBEEF, 1,1,0, 0, 0));
    drive("lw105", 0, ins(7'h00,2,L), 0, 32'h105, 0, 0,        ex(7, 32'h105, 0, 32'hDEADBEEF, 1,1,0, 0, 0));
    drive("lwwrap",0, ins(7'h00,2,L), 0, 32'h500, 0, 4,        ex(7, 32'h504, 0, 32'hDEADBEEF, 1,1,0, 0, 0));
    drive("bne",   0, ins(7'h00,1,B), 0, 3, 3, 8,              ex(0, 0, 0, 0, 0,0,0, 0, 0));
    drive("beq",   0, ins(7'h00,0,B), 0, 3, 3, 8,              ex(0, 0, 0, 0, 0,0,0, 1, 0));
    drive("blt",   0, ins(7'h00,4,B), 0, 32'hFFFFFFFF, 1, 8,   ex(0, 0, 0, 0, 0,0,0, 1, 0));
    drive("bge",   0, ins(7'h00,5,B), 0, 32'hFFFFFFFF, 1, 8,   ex(0, 0, 0, 0, 0,0,0, 0, 0));
    drive("bltu",  0, ins(7'h00,6,B), 0, 32'hFFFFFFFF, 1, 8,   ex(0, 0, 0, 0, 0,0,0, 0, 0));
    drive("bgeu",  0, ins(7'h00,7,B), 0, 32'hFFFFFFFF, 1, 8,   ex(0, 0, 0, 0, 0,0,0, 1, 0));
    drive("jal",   0, ins(7'h00,0,JAL), 32'h40, 0, 0, 16,      ex(2, 0, 0, 32'h44, 1,0,0, 1, 0));
    drive("jalr",  0, ins(7'h00,0,JALR), 32'h80, 32'h200, 0, 0, ex(2, 0, 0, 32'h84, 1,0,0, 2, 0));
    drive("lui",   0, ins(7'h00,0,LUI), 0, 32'hAAAA, 0, 32'h12345000, ex(7, 32'h12345000, 0, 32'h12345000, 1,0,0, 0, 10));
    drive("auipc", 0, ins(7'h00,0,AUIPC), 32'h1000, 5, 0, 32'h2000, ex(7, 32'h3000, 0, 32'h3000, 1,0,0, 0, 0));
    drive("unk",   0, 32'h0000007F, 0, 1, 2, 0,                ex(7, 3, 0, 3, 0,0,0, 0, 0));
    drive("sw200", 0, ins(7'h00,2,S), 0, 32'h200, 32'h11, 0,   ex(7, 32'h200, 0, 32'h200, 0,0,1, 0, 0));
    drive("lw200", 0, ins(7'h00,2,L), 0, 32'h200, 0, 0,        ex(7, 32'h200, 0, 32'h11, 1,1,0, 0, 0));
    drive("rstlw", 1, ins(7'h00,2,L), 0, 32'h104, 0, 0,        ex(7, 32'h104, 0, 32'hDEADBEEF, 1,1,0, 0, 0));
    drive("rstsw", 1, ins(7'h00,2,S), 0, 32'h200, 32'h55, 0,   ex(7, 32'h200, 0, 32'h200, 0,0,1, 0, 0));
    drive("lwclr", 0, ins(7'h00,2,L), 0, 32'h200, 0, 0,        ex(7, 32'h200, 0, 0, 1,1,0, 0, 0));
    drive("lwclr2",0, ins(7'h00,2,L), 0, 32'h100, 0, 4,        ex(7, 32'h104, 0, 0, 1,1,0, 0, 0));
    n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
